// File: rtl/pwm_pkg.sv
// Shared widths, limits and FSM encoding for the PWM fade sequencer.
package pwm_pkg;

    localparam int LEVEL_W    = 8;
    localparam int CHAN_W     = 3;
    localparam int STEP_W     = 4;
    localparam int DIV_W      = 8;
    localparam int MAX_CH     = 7;
    localparam int PWM_PERIOD = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } fade_state_e;

endpackage

// File: rtl/pwm_fade_step.sv
// Next-level arithmetic for one channel: saturating ramp toward the target.
module pwm_fade_step
    import pwm_pkg::*;
(
    input  logic [LEVEL_W-1:0] cur,
    input  logic [LEVEL_W-1:0] tgt,
    input  logic [STEP_W-1:0]  step,
    output logic [LEVEL_W-1:0] nxt
);

    logic [LEVEL_W:0] up_sum;
    logic [LEVEL_W:0] dn_diff;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        nxt     = cur;
        up_sum  = {1'b0, cur} + (LEVEL_W+1)'(step);
        dn_diff = {1'b0, cur} - (LEVEL_W+1)'(step);

        if (step == '0) begin
            nxt = tgt;
        end else if (cur < tgt) begin
            nxt = (up_sum > {1'b0, tgt}) ? tgt : up_sum[LEVEL_W-1:0];
        end else if (cur > tgt) begin
            // Borrow out of bit LEVEL_W means cur < step: clamp to target.
            nxt = (dn_diff[LEVEL_W] || (dn_diff[LEVEL_W-1:0] < tgt)) ? tgt : dn_diff[LEVEL_W-1:0];
        end
    end

endmodule

// File: rtl/pwm_fade_sequencer.sv
// Per-channel PWM fade sequencer: commands set targets, update ticks scan all channels once.
// Optional irq output is built when PWM_FADE_IRQ_EN is defined.
module pwm_fade_sequencer
    import pwm_pkg::*;
#(
    parameter int NUM_CH   = 7,
    parameter int TICK_DIV = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                period_tick,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [CHAN_W-1:0]   cmd_chan,
    input  logic [LEVEL_W-1:0]  cmd_target,
    input  logic [STEP_W-1:0]   cmd_step,
    output logic                wr_en,
    output logic [CHAN_W-1:0]   wr_addr,
    output logic [LEVEL_W-1:0]  wr_level,
    output logic [NUM_CH-1:0]   settled,
    output logic                cmd_err,
`ifdef PWM_FADE_IRQ_EN
    output logic                irq,
`endif
    output logic                overrun
);

    localparam logic [CHAN_W:0]   NUM_CH_L = (CHAN_W+1)'(NUM_CH);
    localparam logic [CHAN_W-1:0] LAST_CH  = CHAN_W'(NUM_CH - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);

    fade_state_e          state_q, state_d;
    logic [CHAN_W-1:0]    idx_q, idx_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 tick_pend_q, tick_pend_d;
    logic [LEVEL_W-1:0]   cur_q  [MAX_CH];
    logic [LEVEL_W-1:0]   cur_d  [MAX_CH];
    logic [LEVEL_W-1:0]   tgt_q  [MAX_CH];
    logic [LEVEL_W-1:0]   tgt_d  [MAX_CH];
    logic [STEP_W-1:0]    step_q [MAX_CH];
    logic [STEP_W-1:0]    step_d [MAX_CH];
    logic                 wr_en_q, wr_en_d;
    logic [CHAN_W-1:0]    wr_addr_q, wr_addr_d;
    logic [LEVEL_W-1:0]   wr_level_q, wr_level_d;
    logic [NUM_CH-1:0]    settled_q, settled_d;
    logic                 cmd_err_q, cmd_err_d;
    logic                 overrun_q, overrun_d;

    logic                 cmd_fire;
    logic                 cmd_bad;
    logic                 upd_tick;
    logic [LEVEL_W-1:0]   scan_next;

    // One arithmetic unit, time-shared by the scan index.
    pwm_fade_step u_step (
        .cur  (cur_q[idx_q]),
        .tgt  (tgt_q[idx_q]),
        .step (step_q[idx_q]),
        .nxt  (scan_next)
    );

    always_comb begin
        cmd_ready = (state_q == IDLE) && !reset;
        cmd_fire  = cmd_valid && cmd_ready;
        cmd_bad   = {1'b0, cmd_chan} >= NUM_CH_L;
        upd_tick  = period_tick && (div_q == DIV_LAST);

        state_d     = state_q;
        idx_d       = idx_q;
        div_d       = div_q;
        tick_pend_d = tick_pend_q;
        cur_d       = cur_q;
        tgt_d       = tgt_q;
        step_d      = step_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_level_d  = wr_level_q;
        cmd_err_d   = cmd_fire && cmd_bad;
        overrun_d   = overrun_q;

        if (period_tick) begin
            div_d = upd_tick ? '0 : div_q + DIV_W'(1);
        end

        // An update tick is only taken while idle with nothing pending; otherwise it is lost.
        if (upd_tick) begin
            if ((state_q == IDLE) && !tick_pend_q) begin
                tick_pend_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (cmd_fire && !cmd_bad) begin
                    tgt_d[cmd_chan]  = cmd_target;
                    step_d[cmd_chan] = cmd_step;
                end
                if (tick_pend_q) begin
                    tick_pend_d = 1'b0;
                    idx_d       = '0;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                if (cur_q[idx_q] != tgt_q[idx_q]) begin
                    cur_d[idx_q] = scan_next;
                    wr_en_d      = 1'b1;
                    wr_addr_d    = idx_q;
                    wr_level_d   = scan_next;
                end
                if (idx_q == LAST_CH) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + CHAN_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        for (int k = 0; k < NUM_CH; k++) begin
            settled_d[k] = (cur_d[k] == tgt_d[k]);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            div_q       <= '0;
            tick_pend_q <= 1'b0;
            // NOTE: the per-channel arrays are small register files, reset explicitly because levels must start at 0.
            for (int k = 0; k < MAX_CH; k++) begin
                cur_q[k]  <= '0;
                tgt_q[k]  <= '0;
                step_q[k] <= '0;
            end
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_level_q  <= '0;
            settled_q   <= '1;
            cmd_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            div_q       <= div_d;
            tick_pend_q <= tick_pend_d;
            cur_q       <= cur_d;
            tgt_q       <= tgt_d;
            step_q      <= step_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_level_q  <= wr_level_d;
            settled_q   <= settled_d;
            cmd_err_q   <= cmd_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_level = wr_level_q;
    assign settled  = settled_q;
    assign cmd_err  = cmd_err_q;
    assign overrun  = overrun_q;

`ifdef PWM_FADE_IRQ_EN
    // Snapshot of "all settled" as the scan starts, including a command landing on that edge.
    logic was_settled_q, was_settled_d;

    always_comb begin
        was_settled_d = was_settled_q;
        if ((state_q == IDLE) && tick_pend_q) begin
            was_settled_d = &settled_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            was_settled_q <= 1'b1;
        end else begin
            was_settled_q <= was_settled_d;
        end
    end

    assign irq = (state_q == DONE) && !was_settled_q && (&settled_q);
`endif

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Self-checking bench: directed vector table, corner sequences and random commands vs a level model.
module tb_pwm_fade_sequencer;

    localparam int NCH = 7;

    logic       clk = 1'b0;
    logic       reset;
    logic       period_tick, cmd_valid, cmd_ready;
    logic [2:0] cmd_chan;
    logic [7:0] cmd_target;
    logic [3:0] cmd_step;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_level;
    logic [6:0] settled;
    logic       cmd_err, overrun;

    logic       period_tick3, cmd_valid3, cmd_ready3;
    logic [2:0] cmd_chan3;
    logic [7:0] cmd_target3;
    logic [3:0] cmd_step3;
    logic       wr_en3;
    logic [2:0] wr_addr3;
    logic [7:0] wr_level3;
    logic [6:0] settled3;
    logic       cmd_err3, overrun3;
`ifdef PWM_FADE_IRQ_EN
    logic       irq, irq3;
`endif

    always #5 clk = ~clk;

    pwm_fade_sequencer #(.NUM_CH(7), .TICK_DIV(1)) dut (
        .clk(clk), .reset(reset), .period_tick(period_tick),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_chan(cmd_chan),
        .cmd_target(cmd_target), .cmd_step(cmd_step),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_level(wr_level),
        .settled(settled), .cmd_err(cmd_err),
`ifdef PWM_FADE_IRQ_EN
        .irq(irq),
`endif
        .overrun(overrun)
    );

    pwm_fade_sequencer #(.NUM_CH(7), .TICK_DIV(3)) dut_div3 (
        .clk(clk), .reset(reset), .period_tick(period_tick3),
        .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_chan(cmd_chan3),
        .cmd_target(cmd_target3), .cmd_step(cmd_step3),
        .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_level(wr_level3),
        .settled(settled3), .cmd_err(cmd_err3),
`ifdef PWM_FADE_IRQ_EN
        .irq(irq3),
`endif
        .overrun(overrun3)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: per-channel levels as plain integers.
    int cur_m [NCH];
    int tgt_m [NCH];
    int stp_m [NCH];
    int obs_wr [NCH];
    int obs_lvl [NCH];
    int nwr;

    typedef struct {
        int         ch;
        int         tgt;
        int         stp;
        bit         exp_err;
        bit         exp_wr;
        int         exp_lvl;
        logic [6:0] exp_settled;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_next(int c, int t, int s);
        if (s == 0) return t;
        if (c < t) return (c + s > t) ? t : c + s;
        if (c > t) return (c - s < t) ? t : c - s;
        return c;
    endfunction

    function automatic logic [6:0] model_settled();
        logic [6:0] r;
        for (int k = 0; k < NCH; k++) r[k] = (cur_m[k] == tgt_m[k]);
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            cur_m[k] = 0;
            tgt_m[k] = 0;
            stp_m[k] = 0;
        end
    endtask

    // Called at the first negedge after the edge that sampled the update tick.
    task automatic observe_scan();
        int exp_lvl [NCH];
        bit exp_w [NCH];
        int k;
        bit e;
        for (int j = 0; j < NCH; j++) begin
            exp_lvl[j] = model_next(cur_m[j], tgt_m[j], stp_m[j]);
            exp_w[j]   = (cur_m[j] != tgt_m[j]);
            obs_wr[j]  = 0;
            obs_lvl[j] = 0;
        end
        nwr = 0;
        for (int c = 1; c <= NCH + 3; c++) begin
            if (c > 1) @(negedge clk);
            k = c - 3;
            e = 1'b0;
            if (k >= 0 && k < NCH) begin
                e          = exp_w[k];
                obs_wr[k]  = int'(wr_en);
                obs_lvl[k] = int'(wr_level);
            end
            check("scan_wr_en", 32'(wr_en), 32'(e));
            if (wr_en) nwr++;
            if (e) begin
                check("scan_wr_addr", 32'(wr_addr), 32'(k));
                check("scan_wr_level", 32'(wr_level), 32'(exp_lvl[k]));
            end
        end
        for (int j = 0; j < NCH; j++) if (exp_w[j]) cur_m[j] = exp_lvl[j];
        check("scan_settled", 32'(settled), 32'(model_settled()));
        check("scan_ready", 32'(cmd_ready), 32'd1);
    endtask

    task automatic tick_scan();
        period_tick = 1'b1;
        @(negedge clk);
        period_tick = 1'b0;
        observe_scan();
    endtask

    task automatic issue_cmd(input int ch, input int t, input int s, input bit with_tick,
                             output bit got_err);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid   = 1'b1;
        cmd_chan    = 3'(ch);
        cmd_target  = 8'(t);
        cmd_step    = 4'(s);
        period_tick = with_tick;
        @(negedge clk);
        cmd_valid   = 1'b0;
        period_tick = 1'b0;
        got_err     = cmd_err;
        check("cmd_err", 32'(cmd_err), 32'(ch >= NCH));
        if (ch < NCH) begin
            tgt_m[ch] = t;
            stp_m[ch] = s;
        end
        if (with_tick) begin
            observe_scan();
        end else begin
            check("cmd_settled", 32'(settled), 32'(model_settled()));
            @(negedge clk);
            check("cmd_err_once", 32'(cmd_err), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [12];
        bit   got_err;
        int   mode, r_ch, r_t, r_s, cnt, exp_cnt;
        bit   extra;

        vecs[0]  = '{2,  10,  4, 1'b0, 1'b1,   4, 7'h7B};
        vecs[1]  = '{2,  10,  4, 1'b0, 1'b1,   8, 7'h7B};
        vecs[2]  = '{2,  10,  4, 1'b0, 1'b1,  10, 7'h7F};
        vecs[3]  = '{2,  10,  4, 1'b0, 1'b0,   0, 7'h7F};
        vecs[4]  = '{0,   3,  0, 1'b0, 1'b1,   3, 7'h7F};
        vecs[5]  = '{0,   0, 15, 1'b0, 1'b1,   0, 7'h7F};
        vecs[6]  = '{6, 255,  0, 1'b0, 1'b1, 255, 7'h7F};
        vecs[7]  = '{6, 255, 15, 1'b0, 1'b0,   0, 7'h7F};
        vecs[8]  = '{7,  99,  5, 1'b1, 1'b0,   0, 7'h7F};
        vecs[9]  = '{5, 200, 15, 1'b0, 1'b1,  15, 7'h5F};
        vecs[10] = '{5,   8,  9, 1'b0, 1'b1,   8, 7'h7F};
        vecs[11] = '{1, 250,  7, 1'b0, 1'b1,   7, 7'h7D};

        reset        = 1'b1;
        period_tick  = 1'b0;
        cmd_valid    = 1'b0;
        cmd_chan     = '0;
        cmd_target   = '0;
        cmd_step     = '0;
        period_tick3 = 1'b0;
        cmd_valid3   = 1'b0;
        cmd_chan3    = '0;
        cmd_target3  = '0;
        cmd_step3    = '0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_ready_low", 32'(cmd_ready), 32'd0);
        check("rst_settled", 32'(settled), 32'h7F);
        reset = 1'b0;
        #1;
        check("rst_ready_release", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_cmd_err", 32'(cmd_err), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_level", 32'(wr_level), 32'd0);

        // Directed table: one command then one scan per record.
        for (int i = 0; i < 12; i++) begin
            issue_cmd(vecs[i].ch, vecs[i].tgt, vecs[i].stp, 1'b0, got_err);
            tick_scan();
            check($sformatf("vec%0d_err", i), 32'(got_err), 32'(vecs[i].exp_err));
            if (vecs[i].ch < NCH) begin
                check($sformatf("vec%0d_wr", i), obs_wr[vecs[i].ch], 32'(vecs[i].exp_wr));
                if (vecs[i].exp_wr)
                    check($sformatf("vec%0d_level", i), obs_lvl[vecs[i].ch], vecs[i].exp_lvl);
            end else begin
                check($sformatf("vec%0d_no_write", i), nwr, 32'd0);
            end
            check($sformatf("vec%0d_settled", i), 32'(settled), 32'(vecs[i].exp_settled));
        end

        // Command coinciding with the tick: the scan must already use the new target.
        issue_cmd(3, 9, 0, 1'b1, got_err);
        check("coincide_wr", obs_wr[3], 32'd1);
        check("coincide_level", obs_lvl[3], 32'd9);

        // Random commands and ticks against the model.
        for (int it = 0; it < 50; it++) begin
            mode = int'($urandom_range(0, 3));
            r_ch = int'($urandom_range(0, 7));
            r_t  = int'($urandom_range(0, 255));
            r_s  = int'($urandom_range(0, 15));
            case (mode)
                0: issue_cmd(r_ch, r_t, r_s, 1'b0, got_err);
                1: tick_scan();
                2: issue_cmd(r_ch, r_t, r_s, 1'b1, got_err);
                default: begin
                    issue_cmd(r_ch, r_t, r_s, 1'b0, got_err);
                    tick_scan();
                end
            endcase
        end

        // Overrun: second period_tick lands mid-scan and must be dropped.
        issue_cmd(4, cur_m[4] ^ 8'h80, 1, 1'b0, got_err);
        exp_cnt = 0;
        for (int k = 0; k < NCH; k++) if (cur_m[k] != tgt_m[k]) exp_cnt++;
        cnt   = 0;
        extra = 1'b0;
        period_tick = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            period_tick = (c == 3);
            if (wr_en) cnt++;
            if (c == 4) check("overrun_set", 32'(overrun), 32'd1);
            if (c >= 11 && !cmd_ready) extra = 1'b1;
        end
        check("overrun_write_count", cnt, exp_cnt);
        check("overrun_no_extra_scan", 32'(extra), 32'd0);
        check("overrun_sticky", 32'(overrun), 32'd1);
        for (int k = 0; k < NCH; k++) cur_m[k] = model_next(cur_m[k], tgt_m[k], stp_m[k]);

        // Divider: TICK_DIV=3, six period_ticks give two scans.
        cmd_valid3  = 1'b1;
        cmd_chan3   = 3'd1;
        cmd_target3 = 8'd50;
        cmd_step3   = 4'd1;
        @(negedge clk);
        cmd_valid3 = 1'b0;
        cnt = 0;
        for (int p = 1; p <= 6; p++) begin
            period_tick3 = 1'b1;
            for (int c = 0; c < 15; c++) begin
                @(negedge clk);
                period_tick3 = 1'b0;
                if (wr_en3) cnt++;
            end
            if (p == 2) check("div3_no_early_scan", cnt, 32'd0);
            if (p == 3) check("div3_first_scan", cnt, 32'd1);
        end
        check("div3_scan_count", cnt, 32'd2);
        check("div3_level", 32'(wr_level3), 32'd2);
        check("div3_addr", 32'(wr_addr3), 32'd1);
        check("div3_no_overrun", 32'(overrun3), 32'd0);

        // Reset asserted while the scan is on channel 3.
        issue_cmd(3, cur_m[3] ^ 8'h80, 5, 1'b0, got_err);
        period_tick = 1'b1;
        @(negedge clk);
        period_tick = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_wr_en", 32'(wr_en), 32'd0);
        check("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
        check("mid_rst_wr_level", 32'(wr_level), 32'd0);
        check("mid_rst_cmd_err", 32'(cmd_err), 32'd0);
        check("mid_rst_overrun", 32'(overrun), 32'd0);
        check("mid_rst_settled", 32'(settled), 32'h7F);
        check("mid_rst_ready_low", 32'(cmd_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("mid_rst_ready_release", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        check("mid_rst_no_write_after", 32'(wr_en), 32'd0);
        model_reset();
        tick_scan();
        check("post_rst_no_writes", nwr, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_fade_sequencer.md
PWM_FADE_SEQUENCER -- requirements
Module: pwm_fade_sequencer

Interface
REQ-001 Parameter NUM_CH, default 7, number of PWM channels sequenced (1..7).
REQ-002 Parameter TICK_DIV, default 1, number of period_tick pulses per ramp update (1..255).
REQ-003 clk  in  1  clock.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 period_tick  in  1  one-cycle pulse at PWM counter roll-over (254->0).
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  command accepted on the same cycle as cmd_valid&&cmd_ready.
REQ-008 cmd_chan  in  3  target channel index.
REQ-009 cmd_target  in  8  final PWM level.
REQ-010 cmd_step  in  4  level change per update; 0 means jump directly to the target.
REQ-011 wr_en  out  1  one-cycle level write strobe to the PWM driver.
REQ-012 wr_addr  out  3  channel written.
REQ-013 wr_level  out  8  level written.
REQ-014 settled  out  NUM_CH  per-channel flag: current level equals target level.
REQ-015 cmd_err  out  1  one-cycle pulse when a command names a channel >= NUM_CH.
REQ-016 overrun  out  1  sticky flag: an update tick arrived while a scan was in progress.

Function
REQ-017 Per-channel state: cur[7:0], tgt[7:0], step[3:0].
REQ-018 The FSM SHALL have three states: IDLE, SCAN, DONE.
- IDLE -> SCAN on an update tick.
- SCAN visits channel 0..NUM_CH-1, one channel per cycle.
- SCAN -> DONE after channel NUM_CH-1.
- DONE -> IDLE unconditionally after one cycle.
REQ-019 Update tick: a divider counts period_tick pulses; every TICK_DIV-th pulse is an update tick, and the divider then wraps to 0.
REQ-020 cmd_ready SHALL be high only in IDLE and not during reset.
REQ-021 An accepted command SHALL load tgt and step for its channel; cur is not changed until the next scan.
REQ-022 If a command and an update tick coincide in IDLE, the command SHALL be applied first, so that scan uses the new tgt.
REQ-023 A command with cmd_chan >= NUM_CH SHALL be accepted, SHALL change no state, and SHALL pulse cmd_err the following cycle.
REQ-024 In SCAN, a channel with cur==tgt SHALL produce no write.
REQ-025 Up-ramp (cur<tgt): next = min(cur+step, tgt), computed 9-bit with no wrap.
REQ-026 Down-ramp (cur>tgt): next = max(cur-step, tgt); cur<step SHALL yield tgt with no underflow.
REQ-027 step==0 SHALL set next = tgt.
REQ-028 When a channel changes, cur SHALL be updated and wr_en/wr_addr/wr_level SHALL be registered; channel k writes k+2 cycles after the edge that sampled the update tick.
REQ-029 When wr_en is low, wr_addr and wr_level SHALL hold their last values.
REQ-030 settled[k] SHALL be registered as (cur[k]==tgt[k]).
REQ-031 A period_tick outside IDLE SHALL still advance the divider; if it completes an update tick, that tick SHALL be dropped and overrun SHALL be set.

Reset
REQ-032 Reset SHALL force the following, regardless of the cycle in which it is asserted:
- state=IDLE, divider=0;
- cur=tgt=0 and step=0 for all channels;
- wr_en=0, wr_addr=0, wr_level=0, cmd_err=0, overrun=0;
- settled all-ones.
REQ-033 Reset asserted mid-scan SHALL abort the scan, and no wr_en SHALL appear in the cycle after reset.

Configuration
REQ-034 Macro PWM_FADE_IRQ_EN SHALL control an optional interrupt output.
- When defined, it adds output irq (1 bit).
- irq pulses for one cycle in DONE when settled transitions from not-all-ones to all-ones.
- When undefined, the irq port and its logic are absent, and all other behaviour is identical.

Structure
REQ-035 Shared package pwm_pkg SHALL hold:
- LEVEL_W=8, CHAN_W=3, MAX_CH=7, PWM_PERIOD=255;
- the FSM state enum.
REQ-036 The next-level arithmetic (REQ-025..027) SHALL be a combinational sub-module pwm_fade_step, instantiated once and shared across the scan.

Verification
REQ-037 Up-ramp: cmd ch2 target=10 step=4, ticks -> wr_level on ch2 = 4, 8, 10, then no further writes; settled[2]=1.
REQ-038 Down-ramp and underflow: ch0 at 3, cmd target=0 step=15, tick -> one write of 0.
REQ-039 Jump and wrap: cmd ch6 target=255 step=0 -> single write of 255; a subsequent target=255 step=15 produces no write.
REQ-040 Bad channel: with NUM_CH=7, cmd_chan=7 -> cmd_err pulses once, no write, and all settled bits unchanged.
REQ-041 Overrun and divider: with TICK_DIV=1, period_tick issued during SCAN -> overrun=1 and no extra scan; with TICK_DIV=3, 6 period_ticks -> exactly 2 scans.
REQ-042 Reset mid-scan: reset in SCAN at channel 3 -> no wr_en after reset, all outputs at reset values, cmd_ready=1 on the first cycle after reset is released.
